// File: rtl/mem_stage_if.sv
// Bundle of the MS stage's pipeline handshakes, WB bus, forward bus,
// flush lines and data-SRAM response. The stage itself uses the slave
// view; the surrounding pipeline (or a bench) drives through the master view.
interface mem_stage_if #(
   parameter int ES_TO_MS_BUS_WD = 175,
   parameter int MS_TO_WS_BUS_WD = 168,
   parameter int MS_FORWARD_WD   = 40
) ();
   logic                       ws_allowin;
   logic                       ms_allowin;
   logic                       es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
   logic                       es_req_inflight;
   logic                       ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
   logic [MS_FORWARD_WD-1:0]   ms_forward;
   logic                       ms_excp_ertn;
   logic                       excp_flush;
   logic                       ertn_flush;
   logic                       data_sram_data_ok;
   logic [31:0]                data_sram_rdata;

   modport master (
      output ws_allowin, es_to_ms_valid, es_to_ms_bus, es_req_inflight,
             excp_flush, ertn_flush, data_sram_data_ok, data_sram_rdata,
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward, ms_excp_ertn
   );

   modport slave (
      input  ws_allowin, es_to_ms_valid, es_to_ms_bus, es_req_inflight,
             excp_flush, ertn_flush, data_sram_data_ok, data_sram_rdata,
      output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_forward, ms_excp_ertn
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from EX, waits for the
// data-SRAM response of issued loads/stores, aligns and extends load data
// and hands the result to WB. Responses owed to instructions killed by a
// flush are counted and dropped as they arrive.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 175,
   parameter int MS_TO_WS_BUS_WD = 168,
   parameter int MS_FORWARD_WD   = 40
) (
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.slave  io
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t                     state;
   logic                       vld_p0;
   logic [ES_TO_MS_BUS_WD-1:0] bus_p0;
   logic [31:0]                data_buf;
   logic [1:0]                 discard_cnt;
   logic [1:0]                 cnt_next;
   logic [2:0]                 cnt_sum;

   logic        flush;
   logic        res_from_mem;
   logic [2:0]  mem_op;
   logic [1:0]  addr;
   logic        req_issued;
   logic        need_data;
   logic        resp_live;
   logic        wait_kill;
   logic        ready_go;
   logic        allowin;
   logic        enter;
   logic [31:0] raw;
   logic [31:0] result;
   logic [MS_TO_WS_BUS_WD-1:0] wb_bus;
   logic [MS_FORWARD_WD-1:0]   fwd;

   // Pick the addressed byte/half of the word and sign/zero extend it.
   function automatic logic [31:0] load_align(input logic [2:0]  op,
                                              input logic [1:0]  a,
                                              input logic [31:0] w);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      sh = w >> {a, 3'b000};
      b  = signed'(sh[7:0]);
      h  = signed'(a[1] ? w[31:16] : w[15:0]);
      case (op)
         3'd1:    load_align = 32'(b);
         3'd2:    load_align = {24'd0, b};
         3'd3:    load_align = 32'(h);
         3'd4:    load_align = {16'd0, h};
         default: load_align = w;
      endcase
   endfunction

   assign flush        = io.excp_flush | io.ertn_flush;
   assign res_from_mem = bus_p0[168];
   assign mem_op       = bus_p0[171:169];
   assign addr         = bus_p0[173:172];
   assign req_issued   = bus_p0[174];

   assign need_data = vld_p0 & req_issued;
   // A response only belongs to the resident instruction once every
   // response owed to flushed instructions has drained.
   assign resp_live = io.data_sram_data_ok & (discard_cnt == 2'd0);
   assign wait_kill = vld_p0 & need_data & (state == S_WAIT);
   assign ready_go  = ~need_data | ((state == S_WAIT) & resp_live) | (state == S_HOLD);
   assign allowin   = ~vld_p0 | (ready_go & io.ws_allowin);
   assign enter     = io.es_to_ms_valid & allowin;

   assign raw    = (state == S_HOLD) ? data_buf : io.data_sram_rdata;
   assign result = res_from_mem ? load_align(mem_op, addr, raw) : bus_p0[71:40];
   assign wb_bus = {bus_p0[167:72], result, bus_p0[39:0]};
   assign fwd    = {vld_p0 & res_from_mem & ~ready_go, result, bus_p0[37:33],
                    bus_p0[38], 1'b1};

   assign io.ms_allowin     = allowin;
   assign io.ms_to_ws_valid = vld_p0 & ready_go & ~flush;
   assign io.ms_to_ws_bus   = wb_bus;
   assign io.ms_forward     = vld_p0 ? fwd : '0;
   assign io.ms_excp_ertn   = vld_p0 & (bus_p0[72] | bus_p0[32]);

   // Count of responses still owed to killed instructions; a data_ok in the
   // flush cycle is charged to the killed WAIT load or to an older discard.
   always_comb begin
      cnt_sum = {1'b0, discard_cnt};
      if (flush) begin
         cnt_sum = {1'b0, discard_cnt} + {2'b00, wait_kill} + {2'b00, io.es_req_inflight};
         if (io.data_sram_data_ok && (discard_cnt != 2'd0 || wait_kill))
            cnt_sum = cnt_sum - 3'd1;
      end else if (io.data_sram_data_ok && discard_cnt != 2'd0) begin
         cnt_sum = cnt_sum - 3'd1;
      end
      cnt_next = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
   end

   // Response-tracking FSM and discard counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         discard_cnt <= 2'd0;
      end else begin
         discard_cnt <= cnt_next;
         if (flush) begin
            state <= S_IDLE;
         end else if (enter) begin
            state <= io.es_to_ms_bus[174] ? S_WAIT : S_IDLE;
         end else begin
            case (state)
               S_WAIT:  if (resp_live) state <= io.ws_allowin ? S_IDLE : S_HOLD;
               S_HOLD:  if (io.ws_allowin) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Stage occupancy.
   always_ff @(posedge clk) begin
      if (reset || flush) vld_p0 <= 1'b0;
      else if (allowin)   vld_p0 <= io.es_to_ms_valid;
   end

   // ---- stage p0 data: EX bus capture and held response while WB stalls ----
   always_ff @(posedge clk) begin
      if (enter) bus_p0 <= io.es_to_ms_bus;
      if ((state == S_WAIT) && resp_live && !io.ws_allowin && !flush)
         data_buf <= io.data_sram_rdata;
   end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with randomized
// fields plus a random instruction stream scored against a residency model.
module tb_mem_stage;
   logic clk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;

   mem_stage_if io ();

   mem_stage dut (.clk(clk), .reset(reset), .io(io));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_idle();
      io.es_to_ms_valid    = 1'b0;
      io.es_req_inflight   = 1'b0;
      io.excp_flush        = 1'b0;
      io.ertn_flush        = 1'b0;
      io.data_sram_data_ok = 1'b0;
      io.data_sram_rdata   = $urandom;
      io.ws_allowin        = 1'b1;
   endtask

   function automatic logic [174:0] mk_bus(input logic [31:0] pc, input logic [31:0] res,
                                           input logic rfm, input logic [2:0] op,
                                           input logic [1:0] a, input logic req,
                                           input logic excp, input logic ertn);
      logic [191:0] r;
      logic [174:0] b;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b = r[174:0];
      b[31:0] = pc; b[32] = ertn; b[71:40] = res; b[72] = excp;
      b[168] = rfm; b[171:169] = op; b[173:172] = a; b[174] = req;
      return b;
   endfunction

   function automatic logic [167:0] exp_wb(input logic [174:0] b, input logic [31:0] res);
      return {b[167:72], res, b[39:0]};
   endfunction

   // Reference load extension from plain arithmetic on the word.
   function automatic logic [31:0] ref_load(input int op, input int a, input logic [31:0] w);
      int unsigned x, bv, hv;
      x  = w;
      bv = (x / (32'd1 << (8 * a))) % 256;
      hv = (x / (32'd1 << (16 * (a / 2)))) % 65536;
      case (op)
         1:       return (bv >= 128) ? bv + 32'hFFFFFF00 : bv;
         2:       return bv;
         3:       return (hv >= 32768) ? hv + 32'hFFFF0000 : hv;
         4:       return hv;
         default: return w;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      set_idle();
      io.es_to_ms_valid = 1'b1;
      io.es_to_ms_bus   = mk_bus($urandom, $urandom, 1'b1, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      step(); step();
      io.es_to_ms_valid = 1'b0;
      sample();
      n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL reset_wb_valid got=%0b exp=0", io.ms_to_ws_valid); else n_pass++;
      n_total++; if (io.ms_forward !== 40'd0) $display("FAIL reset_forward got=%h exp=0", io.ms_forward); else n_pass++;
      n_total++; if (io.ms_excp_ertn !== 1'b0) $display("FAIL reset_excp_ertn got=%0b exp=0", io.ms_excp_ertn); else n_pass++;
      n_total++; if (io.ms_allowin !== 1'b1) $display("FAIL reset_allowin got=%0b exp=1", io.ms_allowin); else n_pass++;
      step();
      reset = 1'b0;
   endtask

   task automatic test_alu();
      logic [174:0] b;
      logic [31:0]  res;
      for (int i = 0; i < 5; i++) begin
         res = (i == 0) ? 32'h1234 : $urandom;
         b = mk_bus($urandom, res, 1'b0, 3'($urandom_range(4)), 2'($urandom), 1'b0, 1'b0, 1'b0);
         step(); io.es_to_ms_valid = 1'b1; io.es_to_ms_bus = b;
         step(); io.es_to_ms_valid = 1'b0;
         sample();
         n_total++; if (io.ms_to_ws_valid !== 1'b1) $display("FAIL alu_valid got=%0b exp=1", io.ms_to_ws_valid); else n_pass++;
         n_total++; if (io.ms_to_ws_bus !== exp_wb(b, res)) $display("FAIL alu_bus got=%h exp=%h", io.ms_to_ws_bus, exp_wb(b, res)); else n_pass++;
         n_total++; if (io.ms_forward !== {1'b0, res, b[37:33], b[38], 1'b1}) $display("FAIL alu_forward got=%h exp=%h", io.ms_forward, {1'b0, res, b[37:33], b[38], 1'b1}); else n_pass++;
         step(); sample();
         n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL alu_leave got=%0b exp=0", io.ms_to_ws_valid); else n_pass++;
      end
   endtask

   task automatic test_load_wait();
      logic [174:0] b;
      logic [31:0]  r, exp;
      int op, a, k;
      for (int i = 0; i < 6; i++) begin
         op = (i == 0) ? 1 : $urandom_range(4);
         a  = (i == 0) ? 2 : $urandom_range(3);
         k  = (i == 0) ? 3 : $urandom_range(3, 1);
         r  = (i == 0) ? 32'h00800000 : $urandom;
         exp = ref_load(op, a, r);
         b = mk_bus($urandom, $urandom, 1'b1, 3'(op), 2'(a), 1'b1, 1'b0, 1'b0);
         step(); io.es_to_ms_valid = 1'b1; io.es_to_ms_bus = b;
         step(); io.es_to_ms_valid = 1'b0;
         for (int c = 0; c < k; c++) begin
            if (c > 0) step();
            sample();
            n_total++; if (io.ms_forward[39] !== 1'b1) $display("FAIL load_pending got=%0b exp=1 cyc=%0d", io.ms_forward[39], c); else n_pass++;
            n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL load_early_valid got=%0b exp=0 cyc=%0d", io.ms_to_ws_valid, c); else n_pass++;
         end
         step(); io.data_sram_data_ok = 1'b1; io.data_sram_rdata = r;
         sample();
         n_total++; if (io.ms_to_ws_valid !== 1'b1) $display("FAIL load_valid got=%0b exp=1", io.ms_to_ws_valid); else n_pass++;
         n_total++; if (io.ms_to_ws_bus !== exp_wb(b, exp)) $display("FAIL load_bus op=%0d a=%0d got=%h exp=%h", op, a, io.ms_to_ws_bus[71:40], exp); else n_pass++;
         n_total++; if (io.ms_forward[39] !== 1'b0) $display("FAIL load_pending_clear got=%0b exp=0", io.ms_forward[39]); else n_pass++;
         if (i == 0) begin
            n_total++; if (io.ms_to_ws_bus[71:40] !== 32'hFFFFFF80) $display("FAIL ldb_result got=%h exp=ffffff80", io.ms_to_ws_bus[71:40]); else n_pass++;
         end
         step(); io.data_sram_data_ok = 1'b0; io.data_sram_rdata = $urandom;
         sample();
         n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL load_leave got=%0b exp=0", io.ms_to_ws_valid); else n_pass++;
      end
   endtask

   task automatic test_hold();
      logic [174:0] b;
      b = mk_bus($urandom, $urandom, 1'b1, 3'd4, 2'd2, 1'b1, 1'b0, 1'b0);
      step(); io.es_to_ms_valid = 1'b1; io.es_to_ms_bus = b;
      step(); io.es_to_ms_valid = 1'b0;
      step(); io.data_sram_data_ok = 1'b1; io.data_sram_rdata = 32'hBEEF0000; io.ws_allowin = 1'b0;
      sample();
      n_total++; if (io.ms_to_ws_bus[71:40] !== 32'h0000BEEF) $display("FAIL hold_first got=%h exp=0000beef", io.ms_to_ws_bus[71:40]); else n_pass++;
      n_total++; if (io.ms_allowin !== 1'b0) $display("FAIL hold_allowin0 got=%0b exp=0", io.ms_allowin); else n_pass++;
      for (int c = 0; c < 2; c++) begin
         step(); io.data_sram_data_ok = 1'b0; io.data_sram_rdata = $urandom; io.ws_allowin = 1'b0;
         sample();
         n_total++; if (io.ms_to_ws_valid !== 1'b1) $display("FAIL hold_valid got=%0b exp=1", io.ms_to_ws_valid); else n_pass++;
         n_total++; if (io.ms_to_ws_bus !== exp_wb(b, 32'h0000BEEF)) $display("FAIL hold_bus got=%h exp=0000beef", io.ms_to_ws_bus[71:40]); else n_pass++;
         n_total++; if (io.ms_forward[39] !== 1'b0) $display("FAIL hold_pending got=%0b exp=0", io.ms_forward[39]); else n_pass++;
      end
      step(); io.ws_allowin = 1'b1; io.data_sram_rdata = $urandom;
      sample();
      n_total++; if (io.ms_to_ws_bus[71:40] !== 32'h0000BEEF) $display("FAIL hold_release got=%h exp=0000beef", io.ms_to_ws_bus[71:40]); else n_pass++;
      n_total++; if (io.ms_allowin !== 1'b1) $display("FAIL hold_allowin1 got=%0b exp=1", io.ms_allowin); else n_pass++;
      step(); sample();
      n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL hold_leave got=%0b exp=0", io.ms_to_ws_valid); else n_pass++;
   endtask

   // Load a fresh ld.w, answer it next cycle with r and expect it on WB.
   task automatic fresh_ldw(input string tag);
      logic [174:0] b;
      logic [31:0]  r;
      r = $urandom;
      b = mk_bus($urandom, $urandom, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(); io.es_to_ms_valid = 1'b1; io.es_to_ms_bus = b;
      step(); io.es_to_ms_valid = 1'b0; io.data_sram_data_ok = 1'b1; io.data_sram_rdata = r;
      sample();
      n_total++; if (io.ms_to_ws_valid !== 1'b1 || io.ms_to_ws_bus[71:40] !== r) $display("FAIL %s_ldw got=%0b/%h exp=1/%h", tag, io.ms_to_ws_valid, io.ms_to_ws_bus[71:40], r); else n_pass++;
      step(); io.data_sram_data_ok = 1'b0;
   endtask

   task automatic enter_wait_load();
      step(); io.es_to_ms_valid = 1'b1;
      io.es_to_ms_bus = mk_bus($urandom, $urandom, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(); io.es_to_ms_valid = 1'b0;
   endtask

   task automatic test_discard();
      logic [174:0] b;
      logic [31:0]  r;
      enter_wait_load();
      step(); io.excp_flush = 1'b1; io.es_req_inflight = 1'b1;
      sample();
      n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL disc_flush_valid got=%0b exp=0", io.ms_to_ws_valid); else n_pass++;
      step(); io.excp_flush = 1'b0; io.es_req_inflight = 1'b0; io.data_sram_data_ok = 1'b1; io.data_sram_rdata = $urandom;
      sample();
      n_total++; if (io.ms_forward[0] !== 1'b0) $display("FAIL disc_empty got=%0b exp=0", io.ms_forward[0]); else n_pass++;
      n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL disc_drop1 got=%0b exp=0", io.ms_to_ws_valid); else n_pass++;
      r = $urandom;
      b = mk_bus($urandom, $urandom, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(); io.data_sram_data_ok = 1'b0; io.es_to_ms_valid = 1'b1; io.es_to_ms_bus = b;
      step(); io.es_to_ms_valid = 1'b0; io.data_sram_data_ok = 1'b1; io.data_sram_rdata = $urandom;
      sample();
      n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL disc_drop2 got=%0b exp=0", io.ms_to_ws_valid); else n_pass++;
      n_total++; if (io.ms_forward[39] !== 1'b1) $display("FAIL disc_pending got=%0b exp=1", io.ms_forward[39]); else n_pass++;
      step(); io.data_sram_rdata = r;
      sample();
      n_total++; if (io.ms_to_ws_valid !== 1'b1 || io.ms_to_ws_bus !== exp_wb(b, r)) $display("FAIL disc_third got=%0b/%h exp=1/%h", io.ms_to_ws_valid, io.ms_to_ws_bus[71:40], r); else n_pass++;
      step(); io.data_sram_data_ok = 1'b0;
   endtask

   task automatic test_flush_coincident();
      for (int i = 0; i < 2; i++) begin
         enter_wait_load();
         step(); io.data_sram_data_ok = 1'b1; io.data_sram_rdata = $urandom;
         if (i == 0) io.excp_flush = 1'b1; else io.ertn_flush = 1'b1;
         sample();
         n_total++; if (io.ms_to_ws_valid !== 1'b0) $display("FAIL coinc_valid%0d got=%0b exp=0", i, io.ms_to_ws_valid); else n_pass++;
         step(); io.data_sram_data_ok = 1'b0; io.excp_flush = 1'b0; io.ertn_flush = 1'b0;
         sample();
         n_total++; if (io.ms_forward[0] !== 1'b0) $display("FAIL coinc_empty%0d got=%0b exp=0", i, io.ms_forward[0]); else n_pass++;
         fresh_ldw("coinc");
      end
   endtask

   task automatic test_reset_midwait();
      enter_wait_load();
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      sample();
      n_total++; if (io.ms_forward[0] !== 1'b0) $display("FAIL rstw_valid got=%0b exp=0", io.ms_forward[0]); else n_pass++;
      n_total++; if (io.ms_allowin !== 1'b1) $display("FAIL rstw_allowin got=%0b exp=1", io.ms_allowin); else n_pass++;
      fresh_ldw("rstw");
   endtask

   task automatic test_excp_flag();
      logic [1:0] f;
      for (int i = 0; i < 4; i++) begin
         f = 2'(i);
         step(); io.es_to_ms_valid = 1'b1;
         io.es_to_ms_bus = mk_bus($urandom, $urandom, 1'b0, 3'd0, 2'd0, 1'b0, f[0], f[1]);
         step(); io.es_to_ms_valid = 1'b0;
         sample();
         n_total++; if (io.ms_excp_ertn !== (f[0] | f[1])) $display("FAIL excp_ertn f=%0d got=%0b exp=%0b", i, io.ms_excp_ertn, f[0] | f[1]); else n_pass++;
      end
      step(); sample();
   endtask

   // Random stream: model tracks which instruction is resident and whether
   // its response has arrived; everything leaves WB-side in issue order.
   task automatic test_back_to_back();
      logic         cur_v = 1'b0, cur_need = 1'b0, cur_got = 1'b0, cur_rfm = 1'b0;
      int           cur_age = 0;
      logic [174:0] cur_bus = '0;
      logic [31:0]  cur_res = '0;
      logic         off_v = 1'b0;
      logic [174:0] off_bus = '0;
      logic         ready, exp_valid, exp_allow;
      int           kind;
      for (int cyc = 0; cyc < 400; cyc++) begin
         step();
         io.ws_allowin = ($urandom_range(3) != 0);
         if (!off_v && $urandom_range(9) < 6) begin
            kind = $urandom_range(2);
            off_bus = mk_bus($urandom, $urandom, kind == 1, 3'($urandom_range(4)),
                             2'($urandom), kind != 0, 1'b0, 1'b0);
            off_v = 1'b1;
         end
         io.es_to_ms_valid = off_v;
         io.es_to_ms_bus   = off_bus;
         io.data_sram_rdata = $urandom;
         io.data_sram_data_ok = 1'b0;
         if (cur_v && cur_need && !cur_got && cur_age >= 1 && $urandom_range(2) == 0) begin
            io.data_sram_data_ok = 1'b1;
            cur_got = 1'b1;
            if (cur_rfm) cur_res = ref_load(int'(cur_bus[171:169]), int'(cur_bus[173:172]), io.data_sram_rdata);
         end
         sample();
         ready     = !cur_need || cur_got;
         exp_valid = cur_v && ready;
         exp_allow = !cur_v || (ready && io.ws_allowin);
         n_total++; if (io.ms_to_ws_valid !== exp_valid) $display("FAIL str_valid cyc=%0d got=%0b exp=%0b", cyc, io.ms_to_ws_valid, exp_valid); else n_pass++;
         n_total++; if (io.ms_allowin !== exp_allow) $display("FAIL str_allowin cyc=%0d got=%0b exp=%0b", cyc, io.ms_allowin, exp_allow); else n_pass++;
         n_total++; if (io.ms_forward[39] !== (cur_v && cur_rfm && !ready)) $display("FAIL str_pending cyc=%0d got=%0b", cyc, io.ms_forward[39]); else n_pass++;
         if (exp_valid) begin
            n_total++; if (io.ms_to_ws_bus !== exp_wb(cur_bus, cur_res)) $display("FAIL str_bus cyc=%0d got=%h exp=%h", cyc, io.ms_to_ws_bus[71:40], cur_res); else n_pass++;
         end
         if (exp_valid && io.ws_allowin) cur_v = 1'b0;
         else if (cur_v) cur_age++;
         if (off_v && exp_allow) begin
            cur_v = 1'b1; cur_bus = off_bus; cur_need = off_bus[174]; cur_rfm = off_bus[168];
            cur_got = 1'b0; cur_age = 0; cur_res = off_bus[71:40]; off_v = 1'b0;
         end
      end
      step();
      set_idle();
   endtask

   initial begin
      reset = 1'b1;
      io.es_to_ms_bus = '0;
      set_idle();
      test_reset();
      test_alu();
      test_load_wait();
      test_hold();
      test_discard();
      test_flush_coincident();
      test_reset_midwait();
      test_excp_flag();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. It accepts one instruction per cycle from EX and waits for the data-SRAM response of loads that EX issued. It aligns and extends load data, then passes the fixed-format WB bus downstream. It also forwards its result and load-pending status to the decode stage, and discards data responses that belong to instructions killed by an exception or `ertn` flush.

## Interface
Parameters:
- ES_TO_MS_BUS_WD, 175: EX→MS bus width.
- MS_TO_WS_BUS_WD, 168: MS→WB bus width.
- MS_FORWARD_WD, 40: forward bus width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MS can accept
- es_to_ms_valid  in  1  EX bus valid
- es_to_ms_bus  in  175  EX→MS bus:
  - [167:0]: same layout as MS→WB.
  - [168]: res_from_mem.
  - [171:169]: mem_op (0 = ld.w, 1 = ld.b, 2 = ld.bu, 3 = ld.h, 4 = ld.hu).
  - [173:172]: addr[1:0].
  - [174]: req_issued, meaning EX got addr_ok for this instruction.
- es_req_inflight  in  1  EX holds an accepted request whose instruction has not yet entered MS.
- ms_to_ws_valid  out  1
- ms_to_ws_bus  out  168:
  - pc[31:0], ertn[32], dest[37:33], gr_we[38], res_from_csr[39].
  - result[71:40], excp[72], excp_num[88:73].
  - csr_we[89], csr_num[103:90], csr_wmask[135:104], csr_wdata[167:136].
- ms_forward  out  40:
  - valid[0], gr_we[1], dest[6:2], result[38:7].
  - load_pending[39], meaning the result is not yet usable.
- ms_excp_ertn  out  1  ms_valid & (excp | ertn); EX suppresses store issue.
- excp_flush, ertn_flush  in  1  flush from WB
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  32  response data

## Operation
- Stage register and valid:
  - ms_valid <= 0 on reset or flush.
  - Otherwise, when ms_allowin, ms_valid <= es_to_ms_valid.
  - The bus register loads on es_to_ms_valid & ms_allowin.
- need_data = ms_valid & req_issued.
- States:
  - IDLE: no data needed or data consumed.
  - WAIT: need_data and no response yet.
  - HOLD: response captured in data_buf while WB is stalled.
- Transitions:
  - WAIT→IDLE: data_ok & ws_allowin.
  - WAIT→HOLD: data_ok & ~ws_allowin.
  - HOLD→IDLE: ws_allowin.
  - Any state→IDLE: flush or reset.
- ms_ready_go = ~need_data | (state==WAIT & data_ok & discard_cnt==0) | state==HOLD.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go & ~flush.
- Load data select: raw = HOLD ? data_buf : data_sram_rdata. Then:
  - Byte lane = raw[8*addr+7 : 8*addr].
  - Half lane = addr[1] ? raw[31:16] : raw[15:0].
  - ld.b and ld.h sign-extend; ld.bu and ld.hu zero-extend.
- result = res_from_mem ? load_data : bus result. All other MS→WB fields pass through unchanged.
- Discard counter: discard_cnt is 2 bits, saturating at 3.
  - On flush: discard_cnt += (ms_valid & need_data & state==WAIT) + es_req_inflight.
  - On data_ok with discard_cnt > 0: decrement, and ignore the response. It does not advance state.
  - If flush and data_ok occur in the same cycle, the data_ok is treated as consumed by the killed instruction. The net increment is reduced by 1 when MS was in WAIT.
- Forward bus:
  - valid = ms_valid.
  - load_pending = ms_valid & res_from_mem & ~ms_ready_go.
- Reset values: ms_valid = 0, state = IDLE, discard_cnt = 0.
  - All valid, forward and flag outputs are 0.
  - Bus contents are don't-care.

## Timing
- A non-load instruction spends 1 cycle in MS. Its result is visible on ms_forward in the same cycle it is resident.
- A load leaves MS in the cycle of its matching data_ok, provided WB allows it. Otherwise it leaves in the cycle after WB asserts ws_allowin, from HOLD.
- data_ok arriving in the same cycle the load enters MS is impossible by contract, because a request is accepted at least 1 cycle before its response.
- Flush is combinational-immediate: ms_to_ws_valid drops in the flush cycle, and ms_valid is 0 on the next cycle.
- The discarded response never reaches WB and never updates data_buf.

## Test plan
- add with result 0x1234 enters MS → ms_to_ws_valid next cycle, result 0x1234, load_pending = 0.
- ld.b at addr[1:0]=2, data_ok 3 cycles later with rdata 0x00800000 → result 0xFFFFFF80. load_pending stays 1 for 3 cycles.
- ld.hu at addr=2, rdata 0xBEEF0000, ws_allowin low on the data_ok cycle → HOLD. Result 0x0000BEEF is emitted when ws_allowin rises.
- Load in WAIT with excp_flush and es_req_inflight=1 → discard_cnt=2. The next two data_ok are dropped, and a following ld.w receives the third response.
- Flush coincident with data_ok while in WAIT → discard_cnt stays 0 and no WB valid is produced.
- Reset asserted mid-WAIT → ms_valid = 0, state = IDLE, discard_cnt = 0 next cycle.
